// File: rtl/qif_neuron_scheduler.sv
// Purpose : time-multiplexed QIF membrane-update controller for N_NEURONS neurons with a spike FIFO.
// Latency : tick -> busy next cycle; neuron k updated at edge T+1+k; done pulse in cycle T+1+N; vmem read 1 cycle.
// Backpressure: spike FIFO drained via spike_valid/spike_ready; a spike into a full FIFO stalls the sweep.
//
// Ports: clk/rst_n (sync, active-high), tick (start timestep), isyn_we/addr/data (synaptic current
// write), vmem_rd_addr/vmem_rd_data (registered debug read), spike_valid/spike_idx/spike_ready
// (spike FIFO head), busy, done (1-cycle pulse), overrun (sticky, tick while busy).
// Optional build macro QIF_SCHED_LEAK_EN adds a linear leak term -(V >>> 4) to the non-spiking update.
module qif_neuron_scheduler #(
  parameter int               N_NEURONS  = 8,
  parameter int               IDX_W      = 3,
  parameter logic signed [7:0] V_RESET   = -8'sd20,
  parameter logic signed [7:0] V_TH      = 8'sd50,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    isyn_we,
  input  logic [IDX_W-1:0]        isyn_addr,
  input  logic signed [7:0]       isyn_data,
  input  logic [IDX_W-1:0]        vmem_rd_addr,
  output logic signed [7:0]       vmem_rd_data,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  input  logic                    spike_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, UPDATE, STALL, DONE} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic signed [7:0]      v_mem [N_NEURONS];
  logic signed [7:0]      i_mem [N_NEURONS];
  logic [IDX_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;

  logic signed [7:0]      v_cur;
  logic signed [7:0]      i_cur;
  logic signed [10:0]     v_ext;
  logic signed [10:0]     q_ext;
  logic signed [10:0]     i_ext;
  logic signed [10:0]     q_sq;
  logic signed [10:0]     sum;
`ifdef QIF_SCHED_LEAK_EN
  logic signed [10:0]     leak_ext;
`endif
  logic signed [7:0]      v_next;
  logic                   spike;
  logic                   fifo_full;
  logic                   pop;
  logic                   push;
  logic                   stall;

  assign v_cur       = v_mem[idx];
  assign i_cur       = i_mem[idx];
  assign spike       = (v_cur >= V_TH);
  assign spike_valid = (count != '0);
  assign spike_idx   = fifo_mem[rd_ptr];
  assign fifo_full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop         = spike_valid && spike_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign stall       = spike && fifo_full && !pop;
  assign push        = (state == UPDATE) && spike && !stall;

  // Shared datapath: V + (V>>>3)^2 + (I>>>2), widened to 11 bits so the square cannot wrap.
  always_comb begin
    v_ext = {{3{v_cur[7]}}, v_cur};
    q_ext = {{6{v_cur[7]}}, v_cur[7:3]};
    i_ext = {{5{i_cur[7]}}, i_cur[7:2]};
    q_sq  = q_ext * q_ext;
`ifdef QIF_SCHED_LEAK_EN
    leak_ext = {{7{v_cur[7]}}, v_cur[7:4]};
    sum      = v_ext + q_sq + i_ext - leak_ext;
`else
    sum      = v_ext + q_sq + i_ext;
`endif
    if (sum > 11'sd127)
      v_next = 8'sd127;
    else if (sum < -11'sd128)
      v_next = -8'sd128;
    else
      v_next = sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      vmem_rd_data <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= V_RESET;
        i_mem[k] <= '0;
      end
    end else begin
      // Read-before-write: returns the value held before this edge's update.
      vmem_rd_data <= v_mem[vmem_rd_addr];
      done         <= 1'b0;
      // The update below reads the pre-edge I, so a same-cycle write lands next timestep.
      if (isyn_we)
        i_mem[isyn_addr] <= isyn_data;
      if (tick && state != IDLE)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (stall) begin
            state <= STALL;
          end else begin
            v_mem[idx] <= spike ? V_RESET : v_next;
            if (idx == IDX_W'(N_NEURONS - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        STALL: begin
          // Neuron idx is re-evaluated from scratch once space is available.
          if (!fifo_full || pop)
            state <= UPDATE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Directed bench for qif_neuron_scheduler: a vector table of (current, ticks, expected V, spikes)
// plus hand sequences for busy/done timing, FIFO stall, overrun, mid-sweep reset and write collision.
// A second instance with V_TH = 127 covers the saturation case.
module tb_qif_neuron_scheduler;
  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              tick = 1'b0;
  logic              isyn_we = 1'b0;
  logic [2:0]        isyn_addr = '0;
  logic signed [7:0] isyn_data = '0;
  logic [2:0]        vmem_rd_addr = '0;
  logic              spike_ready = 1'b0;

  logic signed [7:0] vmem_rd_data, vmem_rd_data_b;
  logic              spike_valid, spike_valid_b;
  logic [2:0]        spike_idx, spike_idx_b;
  logic              busy, busy_b, done, done_b, overrun, overrun_b;

  int test_cnt = 0;
  int fail_cnt = 0;
  int hs_a = 0, hs_b = 0;
  int last_a = -1, last_b = -1;

  always #5 clk = ~clk;

  qif_neuron_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .isyn_we(isyn_we), .isyn_addr(isyn_addr),
    .isyn_data(isyn_data), .vmem_rd_addr(vmem_rd_addr), .vmem_rd_data(vmem_rd_data),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  qif_neuron_scheduler #(.V_TH(8'sd127)) u_dut_th (
    .clk(clk), .rst_n(rst_n), .tick(tick), .isyn_we(isyn_we), .isyn_addr(isyn_addr),
    .isyn_data(isyn_data), .vmem_rd_addr(vmem_rd_addr), .vmem_rd_data(vmem_rd_data_b),
    .spike_valid(spike_valid_b), .spike_idx(spike_idx_b), .spike_ready(spike_ready),
    .busy(busy_b), .done(done_b), .overrun(overrun_b)
  );

  // Handshake monitor: inputs change #1 after posedge, so the negedge sees settled values.
  always @(negedge clk) begin
    if (spike_valid && spike_ready) begin hs_a++; last_a = int'(spike_idx); end
    if (spike_valid_b && spike_ready) begin hs_b++; last_b = int'(spike_idx_b); end
  end

  typedef struct {
    int addr; int idata; int ticks; int rd; int exp_v; int exp_sp; int exp_last; bit use_b;
  } vec_t;
  localparam int NV = 11;
  vec_t vec [NV];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    tick = 1'b0; isyn_we = 1'b0; rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  task automatic write_i(input int k, input int d);
    isyn_we = 1'b1; isyn_addr = 3'(k); isyn_data = 8'(d);
    step();
    isyn_we = 1'b0;
  endtask

  task automatic read_v(input int k, output logic signed [7:0] va, output logic signed [7:0] vb);
    vmem_rd_addr = 3'(k);
    step();
    va = vmem_rd_data; vb = vmem_rd_data_b;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || busy_b) && n < 200) begin step(); n++; end
    if (busy || busy_b) begin
      test_cnt++; fail_cnt++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic signed [7:0] va, vb;
    int base_a, base_b, busy_n, done_n, done_at, n;

    //          addr idata ticks rd exp_v sp last b
    vec[0]  = '{0,    0,   1,  0, -11,  0, 0, 1'b0};
    vec[1]  = '{0,    0,   2,  0,  -7,  0, 0, 1'b0};
    vec[2]  = '{3,   40,   1,  3,  -1,  0, 0, 1'b0};
    vec[3]  = '{3,   40,   4,  3,  35,  0, 0, 1'b0};
    vec[4]  = '{3,   40,   5,  3,  61,  0, 0, 1'b0};
    vec[5]  = '{3,   40,   6,  3, -20,  1, 3, 1'b0};
    vec[6]  = '{1, -128,   2,  1, -39,  0, 0, 1'b0};
    vec[7]  = '{0,  127,   1,  0,  20,  0, 0, 1'b1};
    vec[8]  = '{0,  127,   3,  0, 122,  0, 0, 1'b1};
    vec[9]  = '{0,  127,   4,  0, 127,  0, 0, 1'b1};
    vec[10] = '{0,  127,   5,  0, -20,  1, 0, 1'b1};

    repeat (2) step();
    do_reset();
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_vmem_rd_data", vmem_rd_data, 0);

    // Table-driven membrane trajectories.
    for (int t = 0; t < NV; t++) begin
      do_reset();
      spike_ready = 1'b1;
      write_i(vec[t].addr, vec[t].idata);
      base_a = hs_a; base_b = hs_b;
      for (int k = 0; k < vec[t].ticks; k++) do_tick();
      step(); step();
      read_v(vec[t].rd, va, vb);
      if (vec[t].use_b) begin
        chk($sformatf("vec%0d_v", t), vb, vec[t].exp_v);
        chk($sformatf("vec%0d_spikes", t), hs_b - base_b, vec[t].exp_sp);
        if (vec[t].exp_sp > 0) chk($sformatf("vec%0d_idx", t), last_b, vec[t].exp_last);
      end else begin
        chk($sformatf("vec%0d_v", t), va, vec[t].exp_v);
        chk($sformatf("vec%0d_spikes", t), hs_a - base_a, vec[t].exp_sp);
        if (vec[t].exp_sp > 0) chk($sformatf("vec%0d_idx", t), last_a, vec[t].exp_last);
      end
    end

    // busy spans N+1 cycles, done pulses once in the last of them.
    do_reset();
    spike_ready = 1'b1;
    base_a = hs_a; busy_n = 0; done_n = 0; done_at = -1;
    tick = 1'b1; step(); tick = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = c; end
      step();
    end
    chk("busy_cycles", busy_n, 9);
    chk("done_pulses", done_n, 1);
    chk("done_cycle", done_at, 8);
    chk("no_spikes", hs_a - base_a, 0);

    // Five spikers into a 4-deep FIFO with the consumer stalled.
    do_reset();
    spike_ready = 1'b0;
    for (int k = 0; k < 5; k++) write_i(k, 127);
    do_tick(); do_tick();
    chk("pre_stall_valid", spike_valid, 0);
    tick = 1'b1; step(); tick = 1'b0;
    repeat (20) step();
    chk("stall_busy", busy, 1);
    chk("stall_valid", spike_valid, 1);
    chk("stall_head", spike_idx, 0);
    read_v(4, va, vb);
    chk("stall_v4_held", va, 55);
    spike_ready = 1'b1;
    chk("pulse_head", spike_idx, 0);
    step();
    spike_ready = 1'b0;
    wait_idle();
    read_v(4, va, vb);
    chk("stall_v4_reset", va, -20);
    spike_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      chk($sformatf("drain%0d_valid", j), spike_valid, 1);
      chk($sformatf("drain%0d_idx", j), spike_idx, j);
      step();
    end
    chk("drain_empty", spike_valid, 0);
    chk("stall_no_overrun", overrun, 0);

    // tick while busy is ignored and sets the sticky overrun.
    do_reset();
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    tick = 1'b1; step(); tick = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_idle();
    read_v(0, va, vb);
    chk("overrun_one_step", va, -11);
    step();
    chk("overrun_sticky", overrun, 1);

    // tick in the DONE cycle counts as overrun and does not restart.
    do_reset();
    chk("overrun_cleared", overrun, 0);
    tick = 1'b1; step(); tick = 1'b0;
    n = 0;
    while (!done && n < 50) begin step(); n++; end
    chk("done_seen", done, 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("done_tick_overrun", overrun, 1);
    chk("done_tick_idle", busy, 0);
    step();
    chk("done_tick_still_idle", busy, 0);

    // Reset mid-UPDATE flushes the FIFO and reinitialises V and I.
    do_reset();
    spike_ready = 1'b0;
    write_i(0, 127);
    do_tick(); do_tick(); do_tick();
    chk("midrst_pending", spike_valid, 1);
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    chk("midrst_busy", busy, 1);
    rst_n = 1'b1; step(); rst_n = 1'b0;
    chk("midrst_valid", spike_valid, 0);
    chk("midrst_idle", busy, 0);
    read_v(0, va, vb);
    chk("midrst_v0", va, -20);
    read_v(1, va, vb);
    chk("midrst_v1", va, -20);
    do_tick();
    read_v(0, va, vb);
    chk("midrst_i_cleared", va, -11);

    // Write to I[2] on the very edge neuron 2 is updated.
    do_reset();
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    isyn_we = 1'b1; isyn_addr = 3'd2; isyn_data = 8'sd80;
    step();
    isyn_we = 1'b0;
    wait_idle();
    read_v(2, va, vb);
    chk("collide_old_i", va, -11);
    do_tick();
    read_v(2, va, vb);
    chk("collide_new_i", va, 13);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded, %0d tests run", test_cnt);
    $fatal(1, "timeout");
  end
endmodule
